// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the fifo write-side arbiter
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int FIFO_DEPTH  = 8;
   localparam int DATA_WIDTH  = 32;
   localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; a tie goes to the producer that did not own last
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic owner,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      owner = (req0 & req1) ? ~last_owner : req1;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-limited round-robin sharing of the fifo write port by two producers
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req0,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic                  req1,
   input  logic [DATA_WIDTH-1:0] din1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  accept0,
   output logic                  accept1,
   input  logic                  fifo_full,
   input  logic                  fifo_wr_err,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_din,
   output logic                  ovf_err
);
   import fifo_pkg::*;

   localparam logic [BURST_CNT_W-1:0] LAST_CNT = BURST_CNT_W'(MAX_BURST - 1);

   arb_state_t             state, nxt_state;
   logic [BURST_CNT_W-1:0] burst_cnt, nxt_cnt;
   logic                   last_owner, nxt_last;
   logic                   pick_owner, pick_valid;
   logic                   own_id, own_req, oth_req, own_acc;
   arb_state_t             oth_state;

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner),
      .owner      (pick_owner),
      .valid      (pick_valid)
   );

   // last_owner resets to 1 so that producer 0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         burst_cnt  <= '0;
         last_owner <= 1'b1;
         ovf_err    <= 1'b0;
      end else begin
         state      <= nxt_state;
         burst_cnt  <= nxt_cnt;
         last_owner <= nxt_last;
         if (fifo_wr_err)
            ovf_err <= 1'b1;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = burst_cnt;
      nxt_last  = last_owner;
      own_id    = (state == OWN1);
      own_req   = own_id ? req1 : req0;
      oth_req   = own_id ? req0 : req1;
      own_acc   = own_req & ~fifo_full;
      oth_state = own_id ? OWN0 : OWN1;
      case (state)
         IDLE: begin
            if (pick_valid)
               nxt_state = pick_owner ? OWN1 : OWN0;
         end
         OWN0, OWN1: begin
            // a dropped request wins over a full stall; a stall alone holds everything
            if (!own_req) begin
               nxt_state = oth_req ? oth_state : IDLE;
               nxt_cnt   = '0;
               nxt_last  = own_id;
            end else if (own_acc) begin
               if (burst_cnt == LAST_CNT) begin
                  if (oth_req)
                     nxt_state = oth_state;
                  nxt_cnt  = '0;
                  nxt_last = own_id;
               end else begin
                  nxt_cnt = burst_cnt + 1'b1;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      gnt0       = (state == OWN0);
      gnt1       = (state == OWN1);
      accept0    = gnt0 & req0 & ~fifo_full;
      accept1    = gnt1 & req1 & ~fifo_full;
      fifo_wr_en = accept0 | accept1;
      fifo_din   = gnt1 ? din1 : din0;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a behavioural 8-deep fifo
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0, req1;
   logic [31:0] din0, din1;
   logic        gnt0, gnt1, accept0, accept1;
   logic        fifo_full, fifo_wr_err, fifo_wr_en;
   logic [31:0] fifo_din;
   logic        ovf_err;

   logic        rd;
   logic        force_err;
   logic        model_err;
   logic        err_seen;
   int          fcount;
   logic [31:0] wlog[$];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst;
      logic        r0;
      logic        r1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [4:0]  exp;   // {gnt0, gnt1, accept0, accept1, fifo_wr_en}
      logic [31:0] edin;
   } vec_t;

   vec_t tv[0:19];

   fifo_wr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0        (req0),
      .din0        (din0),
      .req1        (req1),
      .din1        (din1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .accept0     (accept0),
      .accept1     (accept1),
      .fifo_full   (fifo_full),
      .fifo_wr_err (fifo_wr_err),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .ovf_err     (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_full   = (fcount == 8);
   assign fifo_wr_err = model_err | force_err;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fcount    <= 0;
         model_err <= 1'b0;
      end else begin
         fcount    <= fcount + ((fifo_wr_en && fcount < 8) ? 1 : 0) - ((rd && fcount > 0) ? 1 : 0);
         model_err <= fifo_wr_en && (fcount == 8);
      end
   end

   always @(posedge clk) begin
      if (reset_n && fifo_wr_en && fcount < 8)
         wlog.push_back(fifo_din);
      if (model_err)
         err_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [4:0] exp, input logic [31:0] edin);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.exp = exp; v.edin = edin;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      req0      = 1'b0;
      req1      = 1'b0;
      rd        = 1'b0;
      force_err = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wlog.delete();
   endtask

   task automatic wait_words(input string name, input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (wlog.size() >= n) break;
      end
      chk(name, wlog.size(), n);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (tv[i].rst) do_reset();
         @(negedge clk);
         req0 = tv[i].r0; req1 = tv[i].r1; din0 = tv[i].d0; din1 = tv[i].d1;
         #1;
         chk($sformatf("row%0d_outs", i), {gnt0, gnt1, accept0, accept1, fifo_wr_en}, tv[i].exp);
         if (tv[i].exp[0])
            chk($sformatf("row%0d_din", i), fifo_din, tv[i].edin);
      end
   endtask

   initial begin
      // single producer 0: six words, then release
      tv[0]  = mk(1, 1, 0, 32'd1, 0, 5'b00000, 0);
      tv[1]  = mk(0, 1, 0, 32'd1, 0, 5'b10101, 32'd1);
      tv[2]  = mk(0, 1, 0, 32'd2, 0, 5'b10101, 32'd2);
      tv[3]  = mk(0, 1, 0, 32'd3, 0, 5'b10101, 32'd3);
      tv[4]  = mk(0, 1, 0, 32'd4, 0, 5'b10101, 32'd4);
      tv[5]  = mk(0, 1, 0, 32'd5, 0, 5'b10101, 32'd5);
      tv[6]  = mk(0, 1, 0, 32'd6, 0, 5'b10101, 32'd6);
      tv[7]  = mk(0, 0, 0, 0, 0, 5'b10000, 0);
      tv[8]  = mk(0, 0, 0, 0, 0, 5'b00000, 0);
      // both request from idle: four A words, zero-gap handover, four B words
      tv[9]  = mk(1, 1, 1, 32'hA0, 32'hB0, 5'b00000, 0);
      tv[10] = mk(0, 1, 1, 32'hA0, 32'hB0, 5'b10101, 32'hA0);
      tv[11] = mk(0, 1, 1, 32'hA1, 32'hB0, 5'b10101, 32'hA1);
      tv[12] = mk(0, 1, 1, 32'hA2, 32'hB0, 5'b10101, 32'hA2);
      tv[13] = mk(0, 1, 1, 32'hA3, 32'hB0, 5'b10101, 32'hA3);
      tv[14] = mk(0, 0, 1, 0, 32'hB0, 5'b01011, 32'hB0);
      tv[15] = mk(0, 0, 1, 0, 32'hB1, 5'b01011, 32'hB1);
      tv[16] = mk(0, 0, 1, 0, 32'hB2, 5'b01011, 32'hB2);
      tv[17] = mk(0, 0, 1, 0, 32'hB3, 5'b01011, 32'hB3);
      tv[18] = mk(0, 0, 0, 0, 0, 5'b01000, 0);
      tv[19] = mk(0, 0, 0, 0, 0, 5'b00000, 0);

      reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 32'h11; din1 = 32'h22;
      rd = 1'b0; force_err = 1'b0; err_seen = 1'b0;

      // reset held with both requesting
      #8;
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_wr_en", fifo_wr_en, 1'b0);
      chk("rst_ovf", ovf_err, 1'b0);
      chk("rst_din", fifo_din, 32'h11);
      #3 reset_n = 1'b1;
      @(negedge clk);
      chk("first_gnt0", gnt0, 1'b1);
      chk("first_gnt1", gnt1, 1'b0);
      req0 = 1'b0; req1 = 1'b0;

      run_rows(0, 8);
      chk("single_count", wlog.size(), 6);
      for (int i = 0; i < 6 && i < wlog.size(); i++)
         chk($sformatf("single_word%0d", i), wlog[i], 32'(i + 1));

      run_rows(9, 19);
      begin
         logic [31:0] exp_order[8];
         exp_order = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
         chk("both_count", wlog.size(), 8);
         for (int i = 0; i < 8 && i < wlog.size(); i++)
            chk($sformatf("both_word%0d", i), wlog[i], exp_order[i]);
      end

      // full stall: producer 1 writes six, producer 0 fills to eight and keeps requesting
      do_reset();
      req1 = 1'b1; din1 = 32'h100;
      wait_words("fill_p1", 6, 20);
      req1 = 1'b0; req0 = 1'b1; din0 = 32'h200;
      wait_words("fill_p0", 8, 20);
      #1;
      chk("stall_full", fifo_full, 1'b1);
      chk("stall_wr_en", fifo_wr_en, 1'b0);
      chk("stall_acc0", accept0, 1'b0);
      chk("stall_gnt0", gnt0, 1'b1);
      chk("stall_cnt", dut.burst_cnt, 4'd2);
      repeat (3) @(negedge clk);
      #1;
      chk("stall_hold_cnt", dut.burst_cnt, 4'd2);
      chk("stall_hold_gnt0", gnt0, 1'b1);
      chk("stall_hold_wr_en", fifo_wr_en, 1'b0);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      #1;
      chk("unstall_acc0", accept0, 1'b1);
      @(negedge clk);
      #1;
      chk("unstall_count", wlog.size(), 9);
      chk("unstall_cnt", dut.burst_cnt, 4'd3);
      chk("refull_wr_en", fifo_wr_en, 1'b0);
      chk("no_wr_err", err_seen, 1'b0);
      chk("no_ovf", ovf_err, 1'b0);

      // early release after two words while producer 1 waits
      do_reset();
      req0 = 1'b1; req1 = 1'b1; din0 = 32'h50; din1 = 32'h60;
      wait_words("early_two", 2, 10);
      chk("early_cnt2", dut.burst_cnt, 4'd2);
      chk("early_gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      #1;
      chk("early_gnt1", gnt1, 1'b1);
      chk("early_cnt0", dut.burst_cnt, 4'd0);
      chk("early_acc1", accept1, 1'b1);
      chk("early_din", fifo_din, 32'h60);

      // sticky overflow flag, then async reset mid-burst
      do_reset();
      @(negedge clk);
      chk("ovf_before", ovf_err, 1'b0);
      force_err = 1'b1;
      @(negedge clk);
      force_err = 1'b0;
      #1;
      chk("ovf_set", ovf_err, 1'b1);
      @(negedge clk);
      chk("ovf_sticky", ovf_err, 1'b1);
      req0 = 1'b1; din0 = 32'h600;
      wait_words("mid_two", 2, 10);
      #2 reset_n = 1'b0;
      #1;
      chk("async_gnt0", gnt0, 1'b0);
      chk("async_wr_en", fifo_wr_en, 1'b0);
      chk("async_acc0", accept0, 1'b0);
      chk("async_ovf", ovf_err, 1'b0);
      chk("async_cnt", dut.burst_cnt, 4'd0);
      @(negedge clk);
      req0 = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
